// File: rtl/audio_out_pkg.sv
// audio_out_pkg: register map, bit positions and default widths for the audio sample writer
package audio_out_pkg;
  localparam int DATA_SIZE_DEF = 28;
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam int ST_EMPTY = 16;
  localparam int ST_FULL = 17;
  localparam int ST_UNDERRUN = 18;
  localparam int ST_OVERFLOW = 19;
  localparam int ST_IRQ_EN = 20;
  localparam int ST_ENABLE = 21;
  localparam int CT_ENABLE = 0;
  localparam int CT_IRQ_EN = 1;
  localparam int CT_FLUSH = 2;
  localparam int CT_CLR_UR = 3;
  localparam int CT_CLR_OV = 4;
endpackage

// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: show-ahead synchronous FIFO, flush has priority over push and pop
module audio_sample_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic w_push, w_pop;
  assign empty = r_count == '0;
  assign full = r_count == CW'(DEPTH);
  assign count = r_count;
  assign head = r_mem[r_rd_ptr];
  assign w_pop = pop && !empty;
  // a full FIFO still accepts a write when the head leaves in the same cycle
  assign w_push = push && (!full || w_pop);
  always_ff @(posedge clk)
    if (w_push && !flush) r_mem[r_wr_ptr] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
endmodule

// File: rtl/audio_sample_writer.sv
// audio_sample_writer: Avalon-MM sample writes buffered into an Avalon-ST source with refill irq
module audio_sample_writer import audio_out_pkg::*; #(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int FIFO_DEPTH = 16,
  parameter int LOW_WATERMARK = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 chipselect,
  input  logic [1:0]           address,
  input  logic                 read,
  input  logic                 write,
  input  logic [31:0]          writedata,
  output logic [31:0]          read_data,
  output logic                 source_valid,
  output logic [DATA_SIZE-1:0] source_data,
  input  logic                 source_ready,
  output logic                 irq
);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  logic r_enable, r_irq_en, r_underrun, r_overflow;
  logic [31:0] r_read_data;
  logic w_data_wr, w_ctrl_wr, w_pop, w_flush, w_ur_set, w_ov_set, w_empty, w_full, w_unused;
  logic [DATA_SIZE-1:0] w_head;
  logic [CW-1:0] w_count;
  logic [31:0] w_status, w_rdata;
  assign w_data_wr = chipselect && write && address == ADDR_DATA;
  assign w_ctrl_wr = chipselect && write && address == ADDR_CONTROL;
  assign w_flush = w_ctrl_wr && writedata[CT_FLUSH];
  assign source_valid = r_enable && !w_empty;
  assign w_pop = source_valid && source_ready;
  assign w_ov_set = w_data_wr && w_full && !w_pop;
  assign w_ur_set = r_enable && w_empty && source_ready;
  assign source_data = source_valid ? w_head : '0;
  assign irq = r_irq_en && (w_count <= CW'(LOW_WATERMARK) || r_underrun);
  assign read_data = r_read_data;
  assign w_unused = ^writedata[31:DATA_SIZE];
  audio_sample_fifo #(.WIDTH(DATA_SIZE), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(w_data_wr), .pop(w_pop), .flush(w_flush),
    .din(writedata[DATA_SIZE-1:0]), .head(w_head), .count(w_count),
    .empty(w_empty), .full(w_full)
  );
  always_comb begin
    w_status = '0;
    w_status[15:0] = 16'(w_count);
    w_status[ST_EMPTY] = w_empty;
    w_status[ST_FULL] = w_full;
    w_status[ST_UNDERRUN] = r_underrun;
    w_status[ST_OVERFLOW] = r_overflow;
    w_status[ST_IRQ_EN] = r_irq_en;
    w_status[ST_ENABLE] = r_enable;
  end
  assign w_rdata = address == ADDR_STATUS ? w_status :
                   address == ADDR_CONTROL ? 32'({r_irq_en, r_enable}) : '0;
  // sticky flags: a same-cycle set beats the write-1-to-clear
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_enable <= 1'b0;
      r_irq_en <= 1'b0;
      r_underrun <= 1'b0;
      r_overflow <= 1'b0;
      r_read_data <= '0;
    end else begin
      if (chipselect && read) r_read_data <= w_rdata;
      if (w_ctrl_wr) begin
        r_enable <= writedata[CT_ENABLE];
        r_irq_en <= writedata[CT_IRQ_EN];
      end
      r_underrun <= w_ur_set || (r_underrun && !(w_ctrl_wr && writedata[CT_CLR_UR]));
      r_overflow <= w_ov_set || (r_overflow && !(w_ctrl_wr && writedata[CT_CLR_OV]));
    end
endmodule

// File: tb/tb_audio_sample_writer.sv
// tb_audio_sample_writer: queue-based reference model plus directed register/stream scenarios
module tb_audio_sample_writer;
  logic clk = 0, rst = 1, chipselect = 0, read = 0, write = 0, source_ready = 0;
  logic [1:0] address = 0;
  logic [31:0] writedata = 0, read_data;
  logic source_valid, irq;
  logic [27:0] source_data;
  int n_cmp = 0, n_bad = 0;
  always #10 clk = ~clk;

  audio_sample_writer dut (
    .clk(clk), .rst(rst), .chipselect(chipselect), .address(address), .read(read),
    .write(write), .writedata(writedata), .read_data(read_data), .source_valid(source_valid),
    .source_data(source_data), .source_ready(source_ready), .irq(irq)
  );

  logic [27:0] m_q[$];
  bit m_en = 0, m_ie = 0, m_ur = 0, m_ov = 0;
  logic [31:0] m_rd = 0;
  bit t_pop, t_dw, t_cw, t_ovs, t_urs;

  function automatic logic [31:0] m_status();
    return {10'b0, m_en, m_ie, m_ov, m_ur, m_q.size() == 16, m_q.size() == 0, 16'(m_q.size())};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      {m_en, m_ie, m_ur, m_ov} <= 4'b0;
      m_rd <= 0;
    end else begin
      t_pop = m_en && m_q.size() != 0 && source_ready;
      t_dw = chipselect && write && address == 0;
      t_cw = chipselect && write && address == 2;
      t_ovs = t_dw && m_q.size() == 16 && !t_pop;
      t_urs = m_en && m_q.size() == 0 && source_ready;
      if (chipselect && read)
        m_rd <= address == 1 ? m_status() : address == 2 ? {30'b0, m_ie, m_en} : 32'h0;
      m_ur <= t_urs || (m_ur && !(t_cw && writedata[3]));
      m_ov <= t_ovs || (m_ov && !(t_cw && writedata[4]));
      if (t_cw) begin
        m_en <= writedata[0];
        m_ie <= writedata[1];
      end
      if (t_cw && writedata[2]) m_q.delete();
      else begin
        if (t_pop) void'(m_q.pop_front());
        if (t_dw && !t_ovs) m_q.push_back(writedata[27:0]);
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    bit ev;
    ev = m_en && m_q.size() != 0;
    chk("valid", source_valid, ev);
    chk("data", source_data, ev ? m_q[0] : 28'h0);
    chk("irq", irq, m_ie && (m_q.size() <= 4 || m_ur));
    chk("rdata", read_data, m_rd);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] d);
    chipselect = 1; write = 1; address = a; writedata = d;
    tick();
    chipselect = 0; write = 0;
  endtask

  task automatic rd(logic [1:0] a, logic [31:0] exp, string nm);
    chipselect = 1; read = 1; address = a;
    tick();
    chipselect = 0; read = 0;
    chk(nm, read_data, exp);
  endtask

  initial begin
    logic [27:0] e3 [3];
    e3[0] = 28'h1234567; e3[1] = 28'hABCDEF0; e3[2] = 28'h9876543;
    tick(); tick();
    chk("rst_valid", source_valid, 0);
    chk("rst_irq", irq, 0);
    rst = 0;
    tick();
    rd(1, 32'h00010000, "status_idle");
    chk("irq_idle", irq, 0);
    wr(2, 32'h3);
    chk("irq_low", irq, 1);
    for (int i = 0; i < 3; i++) wr(0, {4'hF, e3[i]});
    rd(1, 32'h00300003, "status_cnt3");
    chk("head0", source_data, 32'h1234567);
    source_ready = 1;
    for (int i = 0; i < 3; i++) begin
      chk("drain3", source_data, e3[i]);
      tick();
    end
    tick();
    source_ready = 0;
    chk("valid_empty", source_valid, 0);
    rd(1, 32'h00350000, "status_underrun");
    wr(2, 32'hB);
    rd(1, 32'h00310000, "status_ur_clr");
    for (int i = 0; i < 16; i++) wr(0, 32'h1000000 + i);
    wr(0, 32'h5555555);
    rd(1, 32'h003A0010, "status_ovf");
    wr(2, 32'h13);
    rd(1, 32'h00320010, "status_ov_clr");
    source_ready = 1;
    wr(0, 32'h7777777);
    source_ready = 0;
    rd(1, 32'h00320010, "status_full_pushpop");
    source_ready = 1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_full", source_data, i < 15 ? 32'h1000001 + i : 32'h7777777);
      tick();
    end
    source_ready = 0;
    rd(1, 32'h00310000, "status_drained");
    for (int i = 0; i < 10; i++) wr(0, 32'h2000000 + i);
    wr(2, 32'h2);
    chk("valid_disabled", source_valid, 0);
    rd(1, 32'h0010000A, "status_disabled");
    rd(2, 32'h2, "ctrl_read");
    wr(2, 32'h3);
    chk("irq_high_fill", irq, 0);
    source_ready = 1;
    wr(2, 32'h7);
    source_ready = 0;
    chk("valid_flush", source_valid, 0);
    rd(1, 32'h00310000, "status_flush");
    rd(2, 32'h3, "ctrl_after_flush");
    rd(3, 32'h0, "reserved");
    rd(0, 32'h0, "data_read");
    wr(0, 32'hAAAAAAA);
    chk("valid_pre_rst", source_valid, 1);
    chk("data_pre_rst", source_data, 32'hAAAAAAA);
    rd(1, 32'h00300001, "status_pre_rst");
    rst = 1;
    #1;
    chk("rst_mid_valid", source_valid, 0);
    chk("rst_mid_data", source_data, 0);
    chk("rst_mid_irq", irq, 0);
    chk("rst_mid_rdata", read_data, 0);
    tick(); tick();
    rst = 0;
    tick();
    rd(1, 32'h00010000, "status_after_rst");
    chk("irq_after_rst", irq, 0);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
